// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared mode encoding and default sizes for the stream mux
package stream_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    localparam int N_CH_DEF    = 4;
    localparam int WIDTH_DEF   = 8;
    localparam int SLICE_W_DEF = 2;

endpackage

// File: rtl/mux_n_1_slice.sv
// rtl/mux_n_1_slice.sv - combinational N_CH:1 mux of one SLICE_W-bit slice, one-hot select
module mux_n_1_slice
    import stream_mux_pkg::*;
#(
    parameter int N_CH    = N_CH_DEF,
    parameter int SLICE_W = SLICE_W_DEF
) (
    input  logic [N_CH-1:0]         sel_oh,
    input  logic [N_CH*SLICE_W-1:0] data,
    output logic [SLICE_W-1:0]      y
);

    // AND-OR mux: an all-zero select yields zero
    always_comb begin
        y = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (sel_oh[c]) begin
                y = y | data[c*SLICE_W +: SLICE_W];
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N:1 valid/ready stream mux, fixed or round-robin select; STREAM_MUX_RR_PKT_LOCK_EN adds packet lock
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int N_CH    = N_CH_DEF,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SLICE_W = SLICE_W_DEF,
    parameter int CH_W    = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_last,
    output logic [N_CH-1:0]       in_ready,
    input  logic                  mode,
    input  logic [CH_W-1:0]       sel,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [CH_W-1:0]       out_ch,
    input  logic                  out_ready
);

    localparam int N_SLICE = WIDTH / SLICE_W;

    logic            load_en;
    logic            accept;
    logic            arb_vld;
    logic [CH_W-1:0] arb_ch;
    logic            grant_vld;
    logic [CH_W-1:0] grant_ch;
    logic [N_CH-1:0] grant_oh;
    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] rr_idx;
    logic            ptr_upd_ok;
    logic [WIDTH-1:0] mux_data;

    assign load_en = !out_valid | out_ready;

    // Per-beat arbitration: fixed select, or first valid channel after rr_ptr
    always_comb begin
        arb_vld = 1'b0;
        arb_ch  = '0;
        rr_idx  = '0;
        if (mode_e'(mode) == MODE_FIXED) begin
            for (int c = 0; c < N_CH; c++) begin
                if (sel == CH_W'(c) && in_valid[c]) begin
                    arb_vld = 1'b1;
                    arb_ch  = CH_W'(c);
                end
            end
        end else begin
            for (int k = 1; k <= N_CH; k++) begin
                rr_idx = CH_W'((int'(rr_ptr) + k) % N_CH);
                if (!arb_vld && in_valid[rr_idx]) begin
                    arb_vld = 1'b1;
                    arb_ch  = rr_idx;
                end
            end
        end
    end

`ifdef STREAM_MUX_RR_PKT_LOCK_EN
    logic            locked;
    logic [CH_W-1:0] lock_ch;

    // An open packet pins the grant to its channel, even while that channel idles
    assign grant_vld  = locked ? in_valid[lock_ch] : arb_vld;
    assign grant_ch   = locked ? lock_ch : arb_ch;
    assign ptr_upd_ok = in_last[grant_ch];

    // Lock opens on a non-last beat and closes on the last beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked  <= 1'b0;
            lock_ch <= '0;
        end else if (accept) begin
            locked  <= !in_last[grant_ch];
            lock_ch <= grant_ch;
        end
    end
`else
    logic unused_last;

    assign grant_vld   = arb_vld;
    assign grant_ch    = arb_ch;
    assign ptr_upd_ok  = 1'b1;
    assign unused_last = ^in_last;
`endif

    // One-hot grant drives both the ready vector and the data slices
    always_comb begin
        grant_oh = '0;
        if (grant_vld) begin
            grant_oh[grant_ch] = 1'b1;
        end
    end

    assign in_ready = load_en ? grant_oh : '0;
    assign accept   = load_en & grant_vld;

    for (genvar s = 0; s < N_SLICE; s++) begin : g_slice
        logic [N_CH*SLICE_W-1:0] slice_in;
        for (genvar c = 0; c < N_CH; c++) begin : g_gather
            assign slice_in[c*SLICE_W +: SLICE_W] = in_data[c*WIDTH + s*SLICE_W +: SLICE_W];
        end
        mux_n_1_slice #(
            .N_CH    (N_CH),
            .SLICE_W (SLICE_W)
        ) u_slice (
            .sel_oh (grant_oh),
            .data   (slice_in),
            .y      (mux_data[s*SLICE_W +: SLICE_W])
        );
    end

    // Output register: loads when empty or draining; idle cycles clear valid only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (load_en) begin
            out_valid <= grant_vld;
            if (grant_vld) begin
                out_data <= mux_data;
                out_ch   <= grant_ch;
            end
        end
    end

    // Round-robin pointer remembers the last channel served in RR mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= CH_W'(N_CH - 1);
        end else if (accept && mode_e'(mode) == MODE_RR && ptr_upd_ok) begin
            rr_ptr <= grant_ch;
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - randomized scoreboard bench for stream_mux_rr
module tb_stream_mux_rr;

    logic        clk;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_last;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_ready;

    typedef struct {
        logic [7:0] d;
        int         ch;
    } beat_t;

    beat_t exp_q[$];
    int    ch_log[$];
    int    errors = 0;
    int    checks = 0;

    bit    m_full;
    int    m_ptr;
    bit    m_locked;
    int    m_lock_ch;
    logic [3:0] obs_ready;
    int    beat;
    int    exp_lock[4];

    stream_mux_rr dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_grant();
        if (m_locked) return in_valid[m_lock_ch] ? m_lock_ch : -1;
        if (mode == 1'b0) return in_valid[sel] ? int'(sel) : -1;
        for (int k = 1; k <= 4; k++) begin
            int c = (m_ptr + k) % 4;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        ch_log.delete();
        m_full    = 1'b0;
        m_ptr     = 3;
        m_locked  = 1'b0;
        m_lock_ch = 0;
    endtask

    // Called at posedge+1 after inputs are applied; returns at next posedge+1.
    task automatic tick();
        int         g;
        bit         ld;
        logic [3:0] exp_rdy;
        beat_t      b;
        #1;
        g  = model_grant();
        ld = !m_full || out_ready;
        exp_rdy = (ld && g >= 0) ? (4'b0001 << g) : 4'b0000;
        obs_ready = in_ready;
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, m_full);
        if (ld && g >= 0) begin
            b.d  = in_data[g*8 +: 8];
            b.ch = g;
            exp_q.push_back(b);
        end
        @(posedge clk);
        if (ld) m_full = (g >= 0);
        if (ld && g >= 0) begin
`ifdef STREAM_MUX_RR_PKT_LOCK_EN
            if (!in_last[g]) begin
                m_locked  = 1'b1;
                m_lock_ch = g;
            end else begin
                m_locked = 1'b0;
                if (mode) m_ptr = g;
            end
`else
            if (mode) m_ptr = g;
`endif
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ch", out_ch, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compare the presented beat against the scoreboard head, pop on handshake
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got ch %0d data %0h expected no beat", out_ch, out_data);
                end else begin
                    chk("out_data", out_data, exp_q[0].d);
                    chk("out_ch", out_ch, exp_q[0].ch);
                    if (out_ready) begin
                        ch_log.push_back(int'(out_ch));
                        b = exp_q.pop_front();
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = '0; in_data = '0; in_last = '0;
        mode = 1'b0; sel = '0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("init_out_valid", out_valid, 0);
        chk("init_out_data", out_data, 0);
        chk("init_out_ch", out_ch, 0);
        rst_n = 1'b1;

        // Round-robin, all channels valid: 0,1,2,3,0
        mode = 1'b1; in_valid = 4'hF; in_last = 4'hF; out_ready = 1'b1;
        repeat (6) begin in_data = $urandom; tick(); end
        chk("rr_log_size", ch_log.size() >= 5, 1);
        if (ch_log.size() >= 5) begin
            chk("rr_seq0", ch_log[0], 0);
            chk("rr_seq1", ch_log[1], 1);
            chk("rr_seq2", ch_log[2], 2);
            chk("rr_seq3", ch_log[3], 3);
            chk("rr_seq4", ch_log[4], 0);
        end

        // Backpressure with a full output register
        out_ready = 1'b0;
        repeat (3) begin
            in_data = $urandom;
            tick();
            chk("stall_ready", obs_ready, 4'b0000);
        end
        out_ready = 1'b1;
        tick();
        chk("resume_ready", obs_ready != 4'b0000, 1);
        out_ready = 1'b0;
        tick();

        // Reset while stalled with a held beat
        do_reset();

        // Round-robin with only ch1 and ch3 valid
        mode = 1'b1; in_valid = 4'b1010; out_ready = 1'b1;
        repeat (5) begin in_data = $urandom; tick(); end
        chk("gap_log_size", ch_log.size() >= 4, 1);
        if (ch_log.size() >= 4) begin
            chk("gap_seq0", ch_log[0], 1);
            chk("gap_seq1", ch_log[1], 3);
            chk("gap_seq2", ch_log[2], 1);
            chk("gap_seq3", ch_log[3], 3);
        end

        // Three-beat packet on ch0 competing with ch1
        do_reset();
`ifdef STREAM_MUX_RR_PKT_LOCK_EN
        exp_lock = '{0, 0, 0, 1};
`else
        exp_lock = '{0, 1, 0, 1};
`endif
        mode = 1'b1; out_ready = 1'b1; beat = 0;
        repeat (8) begin
            in_valid = {2'b00, 1'b1, (beat < 3)};
            in_last  = {3'b111, (beat == 2)};
            in_data  = $urandom;
            tick();
            if (obs_ready[0] && in_valid[0]) beat++;
        end
        chk("pkt_log_size", ch_log.size() >= 4, 1);
        if (ch_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk($sformatf("pkt_seq%0d", i), ch_log[i], exp_lock[i]);
        end

        // Fixed select of ch2
        do_reset();
        mode = 1'b0; sel = 2'd2; in_valid = 4'hF; in_last = 4'hF; out_ready = 1'b1;
        in_data = 32'h11A53344;
        tick();
        chk("fixed_ready", obs_ready, 4'b0100);
        chk("fixed_data", out_data, 8'hA5);
        chk("fixed_ch", out_ch, 2);
        sel = 2'd1;
        tick();
        chk("fixed_sel1_ch", out_ch, 1);
        chk("fixed_sel1_data", out_data, 8'h33);

        // Randomized traffic
        repeat (800) begin
            mode      = 1'($urandom);
            sel       = 2'($urandom);
            in_valid  = 4'($urandom);
            in_last   = 4'($urandom) | 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom % 4) != 0;
            tick();
        end

        // Drain
        in_valid = '0; in_last = 4'hF; out_ready = 1'b1;
        repeat (3) tick();
        chk("drain_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
